tipi_nibble_port: RTL and testbench
===================================

# tipi_nibble_port

The Pi-side nibble transfer port for the TIPI CPLD. It sits between the Raspberry Pi GPIO nibble bus and the four TIPI byte registers. It serialises the TI-written TD/TC latches out to the Pi four bits at a time, and assembles Pi-written nibbles into the RD/RC latches that the TI reads at 0x5FF9/0x5FFB. All Pi-side inputs are asynchronous and are synchronised to `clk`.

## Interface
Parameters:
- `SYNC_STAGES`, default 2: synchroniser depth for all Pi inputs; must be 2 or more.

Ports:
- `clk`  in  1  CPLD system clock.
- `r_reset`  in  1  Reset; synchronous, active-high.
- `r_clk`  in  1  Pi nibble strobe, asynchronous; a rising edge advances one nibble.
- `r_nibrst`  in  1  Pi nibble-sequence reset, asynchronous, level.
- `r_sel`  in  2  Register select, asynchronous: 0 = TD (read), 1 = TC (read), 2 = RD (write), 3 = RC (write).
- `r_nib_in`  in  4  Nibble driven by the Pi for writes.
- `r_nib_out`  out  4  Nibble driven to the Pi for reads.
- `r_nib_oe`  out  1  Output enable for the external nibble buffer.
- `td_q`, `tc_q`  in  8  Current TD/TC latch contents, from the TI side.
- `rd_q`, `rc_q`  out  8  RD/RC latch contents, to the TI read mux.
- `rd_wr`, `rc_wr`  out  1  One-cycle pulse when an RD/RC byte is committed.
- `td_ack`, `tc_ack`  out  1  One-cycle pulse when the Pi completes reading a TD/TC byte.

## Operation
- Synchronisation: `r_clk`, `r_nibrst`, `r_sel` and `r_nib_in` each pass through `SYNC_STAGES` flops. A rising edge of synced `r_clk` is detected with one further flop, producing `edge`.
- The state machine has two states, NIB0 (high nibble pending) and NIB1 (low nibble pending). `sel_l` (2 bits) is latched from synced `r_sel` on the NIB0 edge and held for the rest of the byte.
- `r_nibrst` (synced, high): forces NIB0 and suppresses any same-cycle `edge`. No commit and no ack occur. `hi_l`, the snapshot and the R latches are untouched. It has priority over everything except `r_reset`.
- NIB0, no edge: `r_nib_out` is registered as the high nibble of the live `td_q` or `tc_q`, selected by synced `r_sel[0]`.
- NIB0, edge, read select (sel[1]=0): snapshot the full selected byte, set `r_nib_out` to the snapshot's low nibble, go to NIB1.
- NIB0, edge, write select: `hi_l` captures synced `r_nib_in`; go to NIB1.
- NIB1, edge, read: pulse `td_ack` or `tc_ack` per `sel_l`; go to NIB0.
- NIB1, edge, write: commit {`hi_l`, synced `r_nib_in`} to `rd_q` or `rc_q` per `sel_l`, pulse `rd_wr` or `rc_wr`; go to NIB0.
- In NIB1, changes to `r_sel` are ignored until the return to NIB0.
- `r_nib_oe` = synced `r_sel[1]`==0 in NIB0, `sel_l[1]`==0 in NIB1, and forced to 0 while synced `r_nibrst` is high.
- Reset values: NIB0, `sel_l`=0, `hi_l`=0, snapshot=0, `r_nib_out`=0, `r_nib_oe`=0, `rd_q`=0, `rc_q`=0, all pulses 0.
- `r_reset` asserted mid-byte returns the block to NIB0 and discards the partial byte.

## Timing
- Input to `edge`: `SYNC_STAGES`+1 cycles after the `r_clk` rise (3 at the default). State, outputs and pulses update at the end of the `edge` cycle.
- Pi obligations: `r_clk` must stay high at least `SYNC_STAGES`+2 cycles and low at least `SYNC_STAGES`+2 cycles. `r_nib_in` and `r_sel` must be stable from at least 1 cycle before the `r_clk` rise until `SYNC_STAGES`+2 cycles after it.
- `r_nib_out` is valid to the Pi `SYNC_STAGES`+2 cycles after any input change that affects it.
- Commit/ack pulses are exactly 1 `clk` wide; at most one is asserted per cycle.
- A `td_q` change during NIB1 does not alter the low nibble in flight.

## Structure
- `tipi_pkg` holds the `r_sel` encodings (SEL_TD, SEL_TC, SEL_RD, SEL_RC) and the state enum (NIB0, NIB1).
- Sub-module `tipi_sync` is a parameterised-width, `SYNC_STAGES`-deep synchroniser, instantiated once over the concatenated `{r_clk, r_nibrst, r_sel, r_nib_in}`.

## Test plan
- Reset, then idle: `rd_q`=00, `rc_q`=00, `r_nib_oe`=0, no pulses.
- Write RD: `r_sel`=2, nibble A then 5, one `r_clk` pulse each -> `rd_q`=A5, a single `rd_wr` pulse, `rc_q` unchanged.
- Read TC with `tc_q`=3C, `r_sel`=1:
  - before the first strobe, `r_nib_out`=3 and `r_nib_oe`=1;
  - after it, `r_nib_out`=C;
  - change `tc_q` to FF during NIB1 -> `r_nib_out` stays C;
  - second strobe -> one `tc_ack` pulse.
- Nibble resync: write RC high nibble 7, pulse `r_nibrst`, then write 1 and 2 -> `rc_q`=12, exactly one `rc_wr` pulse.
- Select change mid-byte: `r_sel`=3 for nibble 9, switch to 2 before nibble 4 -> `rc_q`=94, `rd_q` unchanged.
- `r_reset` mid-byte after high nibble E, then a full write 6,6 to RD -> `rd_q`=66; no commit of E.

Source files
------------

// File: rtl/tipi_pkg.sv
// tipi_pkg: shared encodings for the TIPI Pi-side nibble port.
//   - r_sel register-select encodings (TD/TC are Pi reads, RD/RC are Pi writes)
//   - nibble sequencing state enum
package tipi_pkg;

   localparam logic [1:0] SEL_TD = 2'd0;
   localparam logic [1:0] SEL_TC = 2'd1;
   localparam logic [1:0] SEL_RD = 2'd2;
   localparam logic [1:0] SEL_RC = 2'd3;

   // NIB0: high nibble pending, NIB1: low nibble pending
   typedef enum logic {
      NIB0 = 1'b0,
      NIB1 = 1'b1
   } nib_state_e;

endpackage

// File: rtl/tipi_sync.sv
// tipi_sync: multi-stage flop synchroniser for a bus of asynchronous inputs.
// Ports:
//   clk      - destination clock
//   r_reset  - synchronous active-high reset, clears every stage
//   d_i      - asynchronous input bus
//   q_o      - synchronised output bus (STAGES clocks of latency)
module tipi_sync #(
   parameter int unsigned WIDTH  = 8,
   parameter int unsigned STAGES = 2
) (
   input  logic             clk,
   input  logic             r_reset,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] stage_q [STAGES];

   always_ff @(posedge clk) begin
      if (r_reset) begin
         for (int unsigned i = 0; i < STAGES; i++) begin
            stage_q[i] <= '0;
         end
      end else begin
         stage_q[0] <= d_i;
         for (int unsigned i = 1; i < STAGES; i++) begin
            stage_q[i] <= stage_q[i-1];
         end
      end
   end

   assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/tipi_nibble_port.sv
// tipi_nibble_port: Pi-side nibble transfer port of the TIPI CPLD.
// Serialises TD/TC bytes to the Pi high nibble first, and assembles two
// Pi-written nibbles into the RD/RC latches.
// Ports:
//   clk, r_reset        - system clock, synchronous active-high reset
//   r_clk               - async Pi nibble strobe (rising edge advances)
//   r_nibrst            - async Pi nibble-sequence reset (level)
//   r_sel[1:0]          - async register select: TD, TC (read), RD, RC (write)
//   r_nib_in[3:0]       - Pi write nibble
//   r_nib_out[3:0]      - nibble to the Pi for reads (registered)
//   r_nib_oe            - external nibble buffer output enable (registered)
//   td_q, tc_q          - TI-side TD/TC latch contents
//   rd_q, rc_q          - RD/RC latch contents to the TI read mux
//   rd_wr, rc_wr        - one-cycle commit pulses
//   td_ack, tc_ack      - one-cycle read-complete pulses
module tipi_nibble_port
   import tipi_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       r_reset,
   input  logic       r_clk,
   input  logic       r_nibrst,
   input  logic [1:0] r_sel,
   input  logic [3:0] r_nib_in,
   output logic [3:0] r_nib_out,
   output logic       r_nib_oe,
   input  logic [7:0] td_q,
   input  logic [7:0] tc_q,
   output logic [7:0] rd_q,
   output logic [7:0] rc_q,
   output logic       rd_wr,
   output logic       rc_wr,
   output logic       td_ack,
   output logic       tc_ack
);

   logic       clk_s;
   logic       nibrst_s;
   logic [1:0] sel_s;
   logic [3:0] nib_s;

   tipi_sync #(
      .WIDTH  (8),
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .clk     (clk),
      .r_reset (r_reset),
      .d_i     ({r_clk, r_nibrst, r_sel, r_nib_in}),
      .q_o     ({clk_s, nibrst_s, sel_s, nib_s})
   );

   logic       clk_prev_q;
   logic       strobe_edge;
   logic [7:0] live_byte;

   nib_state_e state_q;
   logic [1:0] sel_l_q;
   logic [3:0] hi_l_q;
   logic [7:0] snap_q;

   assign strobe_edge = clk_s & ~clk_prev_q;
   assign live_byte   = (sel_s[0]) ? tc_q : td_q;

   always_ff @(posedge clk) begin
      if (r_reset) begin
         clk_prev_q <= 1'b0;
         state_q    <= NIB0;
         sel_l_q    <= '0;
         hi_l_q     <= '0;
         snap_q     <= '0;
         r_nib_out  <= '0;
         r_nib_oe   <= 1'b0;
         rd_q       <= '0;
         rc_q       <= '0;
         rd_wr      <= 1'b0;
         rc_wr      <= 1'b0;
         td_ack     <= 1'b0;
         tc_ack     <= 1'b0;
      end else begin
         clk_prev_q <= clk_s;
         rd_wr      <= 1'b0;
         rc_wr      <= 1'b0;
         td_ack     <= 1'b0;
         tc_ack     <= 1'b0;

         if (nibrst_s) begin
            // Sequence reset swallows any coincident strobe edge.
            state_q   <= NIB0;
            r_nib_oe  <= 1'b0;
            r_nib_out <= live_byte[7:4];
         end else begin
            unique case (state_q)
               NIB0: begin
                  r_nib_oe <= ~sel_s[1];
                  if (strobe_edge) begin
                     sel_l_q <= sel_s;
                     state_q <= NIB1;
                     if (!sel_s[1]) begin
                        // Snapshot so a TI update mid-byte cannot tear the read.
                        snap_q    <= live_byte;
                        r_nib_out <= live_byte[3:0];
                     end else begin
                        hi_l_q <= nib_s;
                     end
                  end else begin
                     r_nib_out <= live_byte[7:4];
                  end
               end
               NIB1: begin
                  r_nib_oe <= ~sel_l_q[1];
                  if (strobe_edge) begin
                     state_q <= NIB0;
                     if (!sel_l_q[1]) begin
                        td_ack <= (sel_l_q != SEL_TC);
                        tc_ack <= (sel_l_q == SEL_TC);
                     end else if (sel_l_q == SEL_RC) begin
                        rc_q  <= {hi_l_q, nib_s};
                        rc_wr <= 1'b1;
                     end else begin
                        rd_q  <= {hi_l_q, nib_s};
                        rd_wr <= 1'b1;
                     end
                  end
               end
               default: state_q <= NIB0;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_tipi_nibble_port.sv
module tb_tipi_nibble_port;

   localparam int unsigned SYNC = 2;

   logic       clk = 1'b0;
   logic       r_reset;
   logic       r_clk;
   logic       r_nibrst;
   logic [1:0] r_sel;
   logic [3:0] r_nib_in;
   logic [3:0] r_nib_out;
   logic       r_nib_oe;
   logic [7:0] td_q;
   logic [7:0] tc_q;
   logic [7:0] rd_q;
   logic [7:0] rc_q;
   logic       rd_wr;
   logic       rc_wr;
   logic       td_ack;
   logic       tc_ack;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;
   int unsigned n_rd = 0;
   int unsigned n_rc = 0;
   int unsigned n_td = 0;
   int unsigned n_tc = 0;
   int unsigned n_multi = 0;

   always #5 clk = ~clk;

   tipi_nibble_port #(
      .SYNC_STAGES (SYNC)
   ) dut (
      .clk       (clk),
      .r_reset   (r_reset),
      .r_clk     (r_clk),
      .r_nibrst  (r_nibrst),
      .r_sel     (r_sel),
      .r_nib_in  (r_nib_in),
      .r_nib_out (r_nib_out),
      .r_nib_oe  (r_nib_oe),
      .td_q      (td_q),
      .tc_q      (tc_q),
      .rd_q      (rd_q),
      .rc_q      (rc_q),
      .rd_wr     (rd_wr),
      .rc_wr     (rc_wr),
      .td_ack    (td_ack),
      .tc_ack    (tc_ack)
   );

   // Pulse counters sampled away from the active edge.
   always @(negedge clk) begin
      if (rd_wr)  n_rd++;
      if (rc_wr)  n_rc++;
      if (td_ack) n_td++;
      if (tc_ack) n_tc++;
      if ((32'(rd_wr) + 32'(rc_wr) + 32'(td_ack) + 32'(tc_ack)) > 1) n_multi++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int unsigned n);
      repeat (n) @(negedge clk);
   endtask

   // One Pi nibble: data set a cycle ahead, strobe high then low long enough.
   task automatic strobe(input logic [3:0] nib);
      r_nib_in = nib;
      cyc(1);
      r_clk = 1'b1;
      cyc(SYNC + 3);
      r_clk = 1'b0;
      cyc(SYNC + 3);
   endtask

   initial begin
      r_reset  = 1'b1;
      r_clk    = 1'b0;
      r_nibrst = 1'b0;
      r_sel    = 2'd2;
      r_nib_in = 4'h0;
      td_q     = 8'h00;
      tc_q     = 8'h00;

      // Reset state, observed while reset is held
      cyc(4);
      chk("rst_rd_q", 32'(rd_q), 32'h00);
      chk("rst_rc_q", 32'(rc_q), 32'h00);
      chk("rst_oe", 32'(r_nib_oe), 32'h0);
      chk("rst_nib_out", 32'(r_nib_out), 32'h0);
      r_reset = 1'b0;
      cyc(8);
      chk("idle_oe", 32'(r_nib_oe), 32'h0);
      chk("idle_pulses", n_rd + n_rc + n_td + n_tc, 0);

      // Write RD = A5
      r_sel = 2'd2;
      strobe(4'hA);
      strobe(4'h5);
      chk("wr_rd_q", 32'(rd_q), 32'hA5);
      chk("wr_rd_pulses", n_rd, 1);
      chk("wr_rc_q", 32'(rc_q), 32'h00);

      // Read TC = 3C with a TI update during NIB1
      tc_q  = 8'h3C;
      td_q  = 8'h81;
      r_sel = 2'd1;
      cyc(SYNC + 3);
      chk("rd_tc_hi", 32'(r_nib_out), 32'h3);
      chk("rd_tc_oe", 32'(r_nib_oe), 32'h1);
      strobe(4'h0);
      chk("rd_tc_lo", 32'(r_nib_out), 32'hC);
      chk("rd_tc_oe_nib1", 32'(r_nib_oe), 32'h1);
      tc_q = 8'hFF;
      cyc(SYNC + 4);
      chk("rd_tc_lo_held", 32'(r_nib_out), 32'hC);
      strobe(4'h0);
      chk("rd_tc_ack", n_tc, 1);
      chk("rd_td_ack", n_td, 0);
      chk("rd_tc_next_hi", 32'(r_nib_out), 32'hF);
      r_sel = 2'd0;
      cyc(SYNC + 3);
      chk("rd_td_hi", 32'(r_nib_out), 32'h8);

      // Nibble resync drops the stray high nibble
      r_sel = 2'd3;
      strobe(4'h7);
      r_nibrst = 1'b1;
      cyc(SYNC + 3);
      chk("nibrst_oe", 32'(r_nib_oe), 32'h0);
      r_nibrst = 1'b0;
      cyc(SYNC + 3);
      strobe(4'h1);
      strobe(4'h2);
      chk("resync_rc_q", 32'(rc_q), 32'h12);
      chk("resync_rc_pulses", n_rc, 1);

      // Select change mid-byte is ignored
      r_sel = 2'd3;
      strobe(4'h9);
      r_sel = 2'd2;
      strobe(4'h4);
      chk("selchg_rc_q", 32'(rc_q), 32'h94);
      chk("selchg_rd_q", 32'(rd_q), 32'hA5);
      chk("selchg_rc_pulses", n_rc, 2);
      chk("selchg_rd_pulses", n_rd, 1);

      // r_reset mid-byte discards the partial byte
      r_sel = 2'd2;
      strobe(4'hE);
      r_reset = 1'b1;
      cyc(3);
      r_reset = 1'b0;
      cyc(SYNC + 3);
      chk("midrst_rd_q", 32'(rd_q), 32'h00);
      chk("midrst_no_commit", n_rd, 1);
      strobe(4'h6);
      strobe(4'h6);
      chk("midrst_rd_66", 32'(rd_q), 32'h66);
      chk("midrst_rd_pulses", n_rd, 2);
      chk("one_pulse_per_cycle", n_multi, 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      n_errors++;
      $display("FAIL watchdog: got timeout expected finish");
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $fatal(1, "watchdog");
   end

endmodule
